// File: rtl/sprite_collision_detector.sv
// Per-frame sprite/sprite and sprite/playfield collision monitor.
// Results are snapshotted at each vsync rise and offered through a valid/ack handshake.
module sprite_collision_detector #(
  parameter int NUM_SPRITES = 4,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   vsync,
  input  logic                   display_on,
  input  logic [NUM_SPRITES-1:0] gfx,
  input  logic                   playfield_gfx,
  input  logic                   result_ack,
  output logic [NUM_SPRITES-1:0] spr_spr_hit,
  output logic [NUM_SPRITES-1:0] spr_pf_hit,
  output logic [CNT_W-1:0]       hit_count,
  output logic                   result_valid,
  output logic                   overrun
);

  typedef enum logic {SYNC_WAIT, RUN} state_t;

  state_t                 state;
  logic                   vsync_d;
  logic [NUM_SPRITES-1:0] acc_ss;
  logic [NUM_SPRITES-1:0] acc_pf;
  logic [CNT_W-1:0]       acc_cnt;

  logic                   vs_rise;
  logic [3:0]             n;
  logic [NUM_SPRITES-1:0] ss_term;
  logic [NUM_SPRITES-1:0] pf_term;
  logic                   pix_hit;

  assign vs_rise = vsync & ~vsync_d;

  always_comb begin
    n = '0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      n = n + 4'(gfx[i]);
    end
    ss_term = (n >= 4'd2) ? gfx : '0;
    pf_term = playfield_gfx ? gfx : '0;
    pix_hit = display_on & ((|ss_term) | (|pf_term));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= SYNC_WAIT;
      vsync_d      <= 1'b0;
      acc_ss       <= '0;
      acc_pf       <= '0;
      acc_cnt      <= '0;
      spr_spr_hit  <= '0;
      spr_pf_hit   <= '0;
      hit_count    <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      vsync_d <= vsync;
      // Ack consumes the pending result; a snapshot on the same edge overrides valid below.
      if (result_valid && result_ack) begin
        result_valid <= 1'b0;
        overrun      <= 1'b0;
      end
      case (state)
        SYNC_WAIT: begin
          acc_ss  <= '0;
          acc_pf  <= '0;
          acc_cnt <= '0;
          if (vs_rise) state <= RUN;
        end
        RUN: begin
          if (vs_rise) begin
            // The vs_rise cycle's own pixel is dropped: outputs take the pre-edge totals.
            spr_spr_hit  <= acc_ss;
            spr_pf_hit   <= acc_pf;
            hit_count    <= acc_cnt;
            acc_ss       <= '0;
            acc_pf       <= '0;
            acc_cnt      <= '0;
            result_valid <= 1'b1;
            if (result_valid && !result_ack) overrun <= 1'b1;
          end else if (display_on) begin
            acc_ss <= acc_ss | ss_term;
            acc_pf <= acc_pf | pf_term;
            if (pix_hit && (acc_cnt != '1)) acc_cnt <= acc_cnt + CNT_W'(1);
          end
        end
        default: state <= SYNC_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_collision_detector.sv
// Bench for sprite_collision_detector: table-driven frames, hand sequences for handshake
// and reset corners, then randomized frames checked against a frame-level reference model.
module tb_sprite_collision_detector;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vsync = 1'b0;
  logic       display_on = 1'b0;
  logic [3:0] gfx = '0;
  logic       playfield_gfx = 1'b0;
  logic       result_ack = 1'b0;
  logic [3:0] spr_spr_hit;
  logic [3:0] spr_pf_hit;
  logic [7:0] hit_count;
  logic       result_valid;
  logic       overrun;

  sprite_collision_detector #(.NUM_SPRITES(4), .CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .vsync        (vsync),
    .display_on   (display_on),
    .gfx          (gfx),
    .playfield_gfx(playfield_gfx),
    .result_ack   (result_ack),
    .spr_spr_hit  (spr_spr_hit),
    .spr_pf_hit   (spr_pf_hit),
    .hit_count    (hit_count),
    .result_valid (result_valid),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: frame totals kept as plain sets/integers, count clamped at snapshot.
  bit         m_run, m_vsd, m_valid, m_ovr;
  logic [3:0] m_ss, m_pf, m_oss, m_opf;
  logic [7:0] m_ocnt;
  int         m_cnt;

  task automatic model_reset();
    m_run = 0; m_vsd = 0; m_valid = 0; m_ovr = 0;
    m_ss = '0; m_pf = '0; m_oss = '0; m_opf = '0; m_ocnt = '0; m_cnt = 0;
  endtask

  task automatic model_cycle(input logic [3:0] g, input logic pf, input logic disp,
                             input logic vs, input logic ack);
    bit rise, snap;
    int pop;
    rise  = vs && !m_vsd;
    m_vsd = vs;
    snap  = m_run && rise;
    if (!m_run && rise) m_run = 1;
    if (snap) begin
      m_oss  = m_ss;
      m_opf  = m_pf;
      m_ocnt = (m_cnt > 255) ? 8'd255 : 8'(m_cnt);
      if (m_valid) m_ovr = !ack;
      m_valid = 1;
      m_ss = '0; m_pf = '0; m_cnt = 0;
    end else begin
      if (m_run && disp) begin
        pop = $countones(g);
        if (pop >= 2) m_ss |= g;
        if (pf) m_pf |= g;
        if ((pop >= 2) || (pf && g != 0)) m_cnt++;
      end
      if (m_valid && ack) begin
        m_valid = 0;
        m_ovr   = 0;
      end
    end
  endtask

  task automatic step(input logic [3:0] g, input logic pf, input logic disp,
                      input logic vs, input logic ack);
    gfx = g; playfield_gfx = pf; display_on = disp; vsync = vs; result_ack = ack;
    model_cycle(g, pf, disp, vs, ack);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Rise cycle carries a full overlap that must be discarded.
  task automatic rise(input logic ack);
    step(4'hF, 1'b1, 1'b1, 1'b1, ack);
  endtask

  task automatic vs_tail();
    step(4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pixels(input logic [3:0] g, input logic pf, input logic disp, input int cnt);
    for (int i = 0; i < cnt; i++) step(g, pf, disp, 1'b0, 1'b0);
  endtask

  task automatic chk_out(input string name, input logic [3:0] ss, input logic [3:0] pf,
                         input logic [7:0] cnt, input logic v, input logic ov);
    chk({name, "_ss"},    32'(spr_spr_hit),  32'(ss));
    chk({name, "_pf"},    32'(spr_pf_hit),   32'(pf));
    chk({name, "_cnt"},   32'(hit_count),    32'(cnt));
    chk({name, "_valid"}, 32'(result_valid), 32'(v));
    chk({name, "_ovr"},   32'(overrun),      32'(ov));
  endtask

  typedef struct {
    logic [3:0] ga; logic pa; int na;
    logic [3:0] gb; logic pb; logic db; int nb;
    logic [3:0] e_ss; logic [3:0] e_pf; logic [7:0] e_cnt;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{4'h0, 1'b0, 0,   4'h0, 1'b0, 1'b1, 0,  4'h0, 4'h0, 8'd0};
    tbl[1] = '{4'h5, 1'b0, 5,   4'h2, 1'b1, 1'b1, 3,  4'h5, 4'h2, 8'd8};
    tbl[2] = '{4'h0, 1'b0, 0,   4'hF, 1'b1, 1'b0, 10, 4'h0, 4'h0, 8'd0};
    tbl[3] = '{4'h3, 1'b0, 300, 4'h0, 1'b0, 1'b1, 0,  4'h3, 4'h0, 8'd255};
    tbl[4] = '{4'h1, 1'b1, 7,   4'h8, 1'b0, 1'b1, 4,  4'h0, 4'h1, 8'd7};
    tbl[5] = '{4'hE, 1'b1, 2,   4'h6, 1'b0, 1'b1, 3,  4'hE, 4'hE, 8'd5};

    model_reset();
    #12;
    chk_out("reset", 4'h0, 4'h0, 8'd0, 1'b0, 1'b0);
    reset = 1'b0;

    idle(3);
    rise(1'b0);
    chk("first_pulse_valid", 32'(result_valid), 32'd0);
    vs_tail();

    foreach (tbl[r]) begin
      pixels(tbl[r].ga, tbl[r].pa, 1'b1, tbl[r].na);
      pixels(tbl[r].gb, tbl[r].pb, tbl[r].db, tbl[r].nb);
      rise(1'b0);
      chk_out($sformatf("tbl%0d", r), tbl[r].e_ss, tbl[r].e_pf, tbl[r].e_cnt, 1'b1, 1'b0);
      step(4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk($sformatf("tbl%0d_ack_valid", r), 32'(result_valid), 32'd0);
      chk($sformatf("tbl%0d_ack_ovr", r), 32'(overrun), 32'd0);
      idle(2);
    end

    // Two snapshots without ack.
    pixels(4'h5, 1'b0, 1'b1, 2);
    rise(1'b0);
    vs_tail();
    pixels(4'h9, 1'b0, 1'b1, 3);
    rise(1'b0);
    chk_out("overrun", 4'h9, 4'h0, 8'd3, 1'b1, 1'b1);
    vs_tail();

    // Ack coincident with the next rise: new data wins, overrun clears.
    pixels(4'h6, 1'b0, 1'b1, 4);
    rise(1'b1);
    chk_out("ack_on_rise", 4'h6, 4'h0, 8'd4, 1'b1, 1'b0);
    vs_tail();

    // Async reset between edges, mid-frame with a pending result.
    pixels(4'hF, 1'b1, 1'b1, 3);
    #2 reset = 1'b1;
    #1;
    chk_out("async_reset", 4'h0, 4'h0, 8'd0, 1'b0, 1'b0);
    model_reset();
    #2 reset = 1'b0;
    idle(2);
    rise(1'b0);
    chk("post_reset_no_snap", 32'(result_valid), 32'd0);
    vs_tail();
    pixels(4'hC, 1'b1, 1'b1, 6);
    rise(1'b0);
    chk_out("post_reset_snap", 4'hC, 4'hC, 8'd6, 1'b1, 1'b0);
    vs_tail();

    // Randomized frames against the reference model, checked every cycle.
    reset = 1'b1;
    model_reset();
    #3 reset = 1'b0;
    for (int f = 0; f < 25; f++) begin
      int len, hi;
      len = $urandom_range(20, 350);
      hi  = $urandom_range(1, 4);
      for (int c = 0; c < len; c++) begin
        step(4'($urandom), ($urandom % 4) == 0, ($urandom % 4) != 0, 1'b0, ($urandom % 8) == 0);
        chk("rand_cycle",
            {14'b0, spr_spr_hit, spr_pf_hit, hit_count, result_valid, overrun},
            {14'b0, m_oss, m_opf, m_ocnt, 1'(m_valid), 1'(m_ovr)});
      end
      for (int c = 0; c < hi; c++) begin
        step(4'($urandom), ($urandom % 4) == 0, ($urandom % 4) != 0, 1'b1, ($urandom % 2) == 0);
        chk("rand_vsync",
            {14'b0, spr_spr_hit, spr_pf_hit, hit_count, result_valid, overrun},
            {14'b0, m_oss, m_opf, m_ocnt, 1'(m_valid), 1'(m_ovr)});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
